// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, their grant/done/rdata returns and the RAM side of mem_arbiter.
// The master modport is the requesters plus RAM; the slave modport is the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, done0, done1, rdata, ram_addr, ram_read, ram_write, ram_wdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, done0, done1, rdata, ram_addr, ram_read, ram_write, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle RAM: IDLE -> ACCESS -> RESP per transaction.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 always win a tie instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              winner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ram_read_q   <= ram_read_d;
            ram_write_q  <= ram_write_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ram_read_d   = 1'b0;
        ram_write_d  = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rdata_d      = rdata_q;

        // Winner is 1 for port 1; a lone requester always wins.
`ifdef MEM_ARB_FIXED_PRIO_EN
        winner = ~bus.req0;
`else
        if (bus.req0 && bus.req1) winner = ~last_grant_q;
        else                      winner = ~bus.req0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = ACCESS;
                    owner_d      = winner;
                    last_grant_d = winner;
                    we_d         = winner ? bus.we1    : bus.we0;
                    addr_d       = winner ? bus.addr1  : bus.addr0;
                    wdata_d      = winner ? bus.wdata1 : bus.wdata0;
                    ram_write_d  = we_d;
                    ram_read_d   = ~we_d;
                    gnt0_d       = ~winner;
                    gnt1_d       = winner;
                end
            end
            ACCESS: begin
                state_d = RESP;
                done0_d = ~owner_q;
                done1_d = owner_q;
                if (!we_q) rdata_d = bus.ram_rdata;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_read  = ram_read_q;
    assign bus.ram_write = ram_write_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural RAM on the RAM side.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   gnt_cnt = 0;
    int   done_cnt = 0;
    int   seq[$];
    logic [DW-1:0] mem [0:15];

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.ram_rdata = mem[bus.ram_addr[3:0]];
    always @(posedge clk) if (bus.ram_write) mem[bus.ram_addr[3:0]] <= bus.ram_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("strobe_mutex", {63'd0, bus.ram_read & bus.ram_write}, 64'd0);
        chk("gnt_mutex", {63'd0, bus.gnt0 & bus.gnt1}, 64'd0);
        chk("done_mutex", {63'd0, bus.done0 & bus.done1}, 64'd0);
        if (bus.gnt0 || bus.gnt1) gnt_cnt++;
        if (bus.done0 || bus.done1) done_cnt++;
        if (bus.gnt0) seq.push_back(0);
        if (bus.gnt1) seq.push_back(1);
    end

    task automatic txn(input bit p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        @(posedge clk); #1;
        if (!p) begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
        else    begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((p ? bus.gnt1 : bus.gnt0) == 1'b0 && n < 8);
        chk("gnt_latency", n, 2);
        chk("gnt_mine", p ? bus.gnt1 : bus.gnt0, 1);
        chk("gnt_other", p ? bus.gnt0 : bus.gnt1, 0);
        chk("ram_write", bus.ram_write, w);
        chk("ram_read", bus.ram_read, !w);
        chk("ram_addr", bus.ram_addr, a);
        if (w) chk("ram_wdata", bus.ram_wdata, d);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("done_mine", p ? bus.done1 : bus.done0, 1);
        chk("done_other", p ? bus.done0 : bus.done1, 0);
        chk("strobes_resp", {bus.ram_read, bus.ram_write}, 0);
    endtask

    initial begin
        int n;
        int exp_seq [4];
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
        chk("rst_done", {bus.done0, bus.done1}, 0);
        chk("rst_strobes", {bus.ram_read, bus.ram_write}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);

        // Port 0 write then read back
        txn(1'b0, 1'b1, 64'd0, 64'd5);
        chk("rdata_after_write", bus.rdata, 0);
        txn(1'b0, 1'b0, 64'd0, 64'd0);
        chk("rdata_read0", bus.rdata, 5);

        // Port 1 write, port 0 reads it
        txn(1'b1, 1'b1, 64'd1, 64'd684);
        chk("rdata_kept_p1_write", bus.rdata, 5);
        txn(1'b0, 1'b0, 64'd1, 64'd0);
        chk("rdata_read1", bus.rdata, 684);

        // Reset during ACCESS of a write to addr 2
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 64'd2; bus.wdata0 = 64'd9;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.gnt0 && n < 8);
        chk("abort_gnt", bus.gnt0, 1);
        reset = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("abort_done", {bus.done0, bus.done1}, 0);
        chk("abort_strobes", {bus.ram_read, bus.ram_write}, 0);
        chk("abort_gnt_clr", {bus.gnt0, bus.gnt1}, 0);
        chk("abort_rdata", bus.rdata, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_no_late_done", {bus.done0, bus.done1}, 0);
        txn(1'b1, 1'b0, 64'd1, 64'd0);
        chk("rdata_after_abort", bus.rdata, 684);

        // Both ports saturated from reset
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seq.delete();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 64'd0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 64'd1;
        repeat (16) @(negedge clk);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        chk("grant_seq_len", (seq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_seq[%0d]", i), (i < seq.size()) ? seq[i] : 2, exp_seq[i]);
        chk("done_per_txn", done_cnt, gnt_cnt - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, width of all address buses.
REQ-002 Parameter DATA_W, default 64, width of all data buses.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from port 0 (CPU data) and port 1 (loader/debug).
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; held with reqN.
REQ-007 addr0, addr1  input  ADDR_W each  request address; held with reqN.
REQ-008 wdata0, wdata1  input  DATA_W each  write data; held with reqN.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse; request captured.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  DATA_W  read result, valid from the done pulse until the next completed read.
REQ-012 ram_addr  output  ADDR_W  RAM address.
REQ-013 ram_read, ram_write  output  1 each  RAM read/write strobes.
REQ-014 ram_wdata  output  DATA_W  RAM write data.
REQ-015 ram_rdata  input  DATA_W  RAM combinational read data.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when req0|req1; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-017 On the IDLE->ACCESS edge the winner's we/addr/wdata shall be latched; requester inputs are ignored outside IDLE.
REQ-018 gntN shall be high for exactly the ACCESS cycle of port N's transaction; doneN exactly for the RESP cycle.
REQ-019 During ACCESS: ram_addr/ram_wdata = latched values, ram_write = latched we, ram_read = ~latched we; both strobes 0 in IDLE and RESP.
REQ-020 ram_read and ram_write shall never be high in the same cycle; all ram_* outputs shall be driven from registers.
REQ-021 On a read, rdata shall capture ram_rdata at the end of ACCESS; on a write, rdata shall keep its prior value.
REQ-022 Latency: request sampled in IDLE at edge T -> gnt in cycle T+1 -> done in cycle T+2; one transaction per 3 cycles.
REQ-023 Arbitration (round-robin): single requester wins; both requesting -> port other than last_grant wins; last_grant updates on each grant.
REQ-024 A requester holding reqN high after doneN issues a new request in the following IDLE cycle; with both ports saturated, grants alternate 0,1,0,1.
REQ-025 Requester shall hold reqN, weN, addrN, wdataN stable until gntN; dropping reqN before grant withdraws the request without side effect.

Reset
REQ-026 reset high at a rising edge shall force state IDLE, last_grant = 1 (port 0 wins first tie), rdata = 0, all gnt/done/ram_* outputs = 0.
REQ-027 reset during ACCESS or RESP shall abort the transaction: no doneN pulse, strobes 0 from the next cycle, rdata cleared.

Configuration
REQ-028 Macro MEM_ARB_FIXED_PRIO_EN: when defined, port 0 shall always win a tie and last_grant is not used; when undefined, REQ-023 round-robin applies.

Verification
REQ-029 Port 0 write addr=0 data=5, then read addr=0 -> gnt0 at T+1, done0 at T+2, ram_write for one cycle; read returns rdata=5.
REQ-030 Port 1 write addr=1 data=684 while port 0 idle, then port 0 read addr=1 -> rdata=684 on done0; port 1 rdata unchanged after its write.
REQ-031 req0 and req1 asserted same cycle after reset and held -> grant order 0,1,0,1 (without macro); 0,0,0 (with MEM_ARB_FIXED_PRIO_EN).
REQ-032 reset asserted in ACCESS of a write to addr=2 -> no done pulse, all strobes 0 next cycle, state IDLE, rdata=0.
REQ-033 Every cycle of all scenarios -> assertion ram_read & ram_write never 1; gnt0 & gnt1 never 1; at most one done per transaction.
